// File: rtl/delta_event_pkg.sv
// Shared types and constants for the delta event logger.
//   state_t       : capture FSM states (IDLE, ACK, SETTLE)
//   entry_t       : logged entry layout {data, ts} at the default widths
//   SETTLE_CYCLES : cycles spent ignoring VALUE_CHANGE after an acknowledge
package delta_event_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_TS_WIDTH   = 16;
  localparam int SETTLE_CYCLES  = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACK    = 2'd1,
    SETTLE = 2'd2
  } state_t;

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] data;
    logic [DEF_TS_WIDTH-1:0]   ts;
  } entry_t;

endpackage

// File: rtl/delta_event_logger_fifo.sv
// sync_fifo_fwft: synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (flushes pointers/level)
//   push       : write push_data when not full (ignored when full)
//   pop        : drop the head entry when not empty (ignored when empty)
//   pop_data   : head entry, valid whenever empty=0
//   full/empty : occupancy flags
//   level      : occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo_fwft #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign level    = count_q;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage carries no reset; a flush only clears pointers and level.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/delta_event_logger.sv
// delta_event_logger: logs each change reported by the delta register as a
// {value, timestamp} entry in a FWFT FIFO and acknowledges it with READ_EVENT.
// Ports:
//   CLK, RST      : clock, synchronous active-high reset
//   VALUE_CHANGE  : change pending from the delta register
//   VALUE_IN      : value to log
//   READ_EVENT    : one-cycle acknowledge back to the delta register
//   EVT_VALID/EVT_READY/EVT_DATA/EVT_TS : head-of-FIFO valid/ready interface
//   LEVEL, FULL   : FIFO occupancy
//   STALL         : change pending while the FIFO is full (held, not acked)
//   DROP_COUNT    : saturating count of discarded changes (drop build only)
// Build option DELTA_EVENT_LOGGER_DROP_EN: a change arriving while full is
// acknowledged and discarded instead of stalled; STALL is then always 0.
module delta_event_logger
  import delta_event_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TS_WIDTH   = DEF_TS_WIDTH,
  parameter int DEPTH      = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   VALUE_CHANGE,
  input  logic [DATA_WIDTH-1:0]  VALUE_IN,
  output logic                   READ_EVENT,
  output logic                   EVT_VALID,
  input  logic                   EVT_READY,
  output logic [DATA_WIDTH-1:0]  EVT_DATA,
  output logic [TS_WIDTH-1:0]    EVT_TS,
  output logic [$clog2(DEPTH):0] LEVEL,
  output logic                   FULL,
  output logic                   STALL
`ifdef DELTA_EVENT_LOGGER_DROP_EN
  ,
  output logic [7:0]             DROP_COUNT
`endif
);

`ifdef DELTA_EVENT_LOGGER_DROP_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  // Same layout as entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [TS_WIDTH-1:0]   ts;
  } log_entry_t;

  state_t          state_q;
  state_t          state_d;
  logic [3:0]      settle_cnt_q;
  logic [TS_WIDTH-1:0] ts_q;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic            change_while_full;
  log_entry_t      wr_entry;
  log_entry_t      rd_entry;

  // Free-running timestamp, wraps silently.
  always_ff @(posedge CLK) begin
    if (RST) ts_q <= '0;
    else     ts_q <= ts_q + 1'b1;
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      settle_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= (state_q == SETTLE) ? settle_cnt_q + 1'b1 : '0;
    end
  end

  // Next state; the full decision uses the pre-edge FULL, so a same-edge pop
  // does not enable a capture until the following IDLE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (VALUE_CHANGE && (!fifo_full || DROP_EN)) state_d = ACK;
      ACK:     state_d = SETTLE;
      SETTLE:  if (settle_cnt_q == 4'(SETTLE_CYCLES - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    READ_EVENT        = (state_q == ACK);
    change_while_full = (state_q == IDLE) && VALUE_CHANGE && fifo_full;
    push              = (state_q == IDLE) && VALUE_CHANGE && !fifo_full;
    STALL             = change_while_full && !DROP_EN;
    wr_entry.data     = VALUE_IN;
    wr_entry.ts       = ts_q;
  end

  assign EVT_VALID = !fifo_empty;
  assign pop       = EVT_VALID && EVT_READY;
  assign EVT_DATA  = rd_entry.data;
  assign EVT_TS    = rd_entry.ts;
  assign FULL      = fifo_full;

  sync_fifo_fwft #(
    .W     ($bits(log_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (push),
    .push_data (wr_entry),
    .pop       (pop),
    .pop_data  (rd_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (LEVEL)
  );

`ifdef DELTA_EVENT_LOGGER_DROP_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST)                                      drop_cnt_q <= '0;
    else if (change_while_full && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 1'b1;
  end

  assign DROP_COUNT = drop_cnt_q;
`endif

endmodule

// File: tb/tb_delta_event_logger.sv
module tb_delta_event_logger;

  localparam int DEPTH = 8;
`ifdef DELTA_EVENT_LOGGER_DROP_EN
  localparam bit DROP_MODE = 1'b1;
`else
  localparam bit DROP_MODE = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        VALUE_CHANGE = 1'b0;
  logic [15:0] VALUE_IN = '0;
  logic        EVT_READY = 1'b0;
  logic        READ_EVENT;
  logic        EVT_VALID;
  logic [15:0] EVT_DATA;
  logic [15:0] EVT_TS;
  logic [3:0]  LEVEL;
  logic        FULL;
  logic        STALL;
`ifdef DELTA_EVENT_LOGGER_DROP_EN
  logic [7:0]  DROP_COUNT;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model: queue of logged entries, a timestamp, and the number of
  // cycles before the logger will look at VALUE_CHANGE again.
  logic [15:0] q_data[$];
  logic [15:0] q_ts[$];
  logic [15:0] m_ts = '0;
  int          m_cool = 0;
  bit          m_ack = 1'b0;
  int          m_drop = 0;

  delta_event_logger #(.DATA_WIDTH(16), .TS_WIDTH(16), .DEPTH(DEPTH)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .VALUE_CHANGE (VALUE_CHANGE),
    .VALUE_IN     (VALUE_IN),
    .READ_EVENT   (READ_EVENT),
    .EVT_VALID    (EVT_VALID),
    .EVT_READY    (EVT_READY),
    .EVT_DATA     (EVT_DATA),
    .EVT_TS       (EVT_TS),
    .LEVEL        (LEVEL),
    .FULL         (FULL),
    .STALL        (STALL)
`ifdef DELTA_EVENT_LOGGER_DROP_EN
    ,
    .DROP_COUNT   (DROP_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  // Advance the model by one clock using the inputs currently applied, then
  // step past the edge so outputs can be sampled.
  task automatic tick();
    bit pre_full, do_pop, cap, drp;
    if (RST) begin
      q_data.delete();
      q_ts.delete();
      m_ts = '0;
      m_cool = 0;
      m_ack = 1'b0;
      m_drop = 0;
    end else begin
      pre_full = (q_data.size() == DEPTH);
      do_pop   = (q_data.size() > 0) && EVT_READY;
      cap      = (m_cool == 0) && VALUE_CHANGE && !pre_full;
      drp      = DROP_MODE && (m_cool == 0) && VALUE_CHANGE && pre_full;
      if (do_pop) begin
        void'(q_data.pop_front());
        void'(q_ts.pop_front());
      end
      if (cap) begin
        q_data.push_back(VALUE_IN);
        q_ts.push_back(m_ts);
      end
      if (drp && m_drop != 255) m_drop++;
      m_ack  = cap || drp;
      m_cool = (cap || drp) ? 2 : ((m_cool > 0) ? m_cool - 1 : 0);
      m_ts   = m_ts + 16'd1;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; VALUE_CHANGE = 1'b0; EVT_READY = 1'b0;
    tick(); tick();
    checks++; if (READ_EVENT !== 1'b0) begin failures++; $display("FAIL reset_read_event got=%0b exp=0", READ_EVENT); end
    checks++; if (EVT_VALID !== 1'b0) begin failures++; $display("FAIL reset_evt_valid got=%0b exp=0", EVT_VALID); end
    checks++; if (LEVEL !== 4'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", LEVEL); end
    checks++; if (FULL !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", FULL); end
    checks++; if (STALL !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", STALL); end
`ifdef DELTA_EVENT_LOGGER_DROP_EN
    checks++; if (DROP_COUNT !== 8'd0) begin failures++; $display("FAIL reset_drop_count got=%0d exp=0", DROP_COUNT); end
`endif
    RST = 1'b0;
  endtask

  task automatic test_single_capture();
    // Timestamp is 0 after the reset edge; five idle edges bring it to 5.
    repeat (5) tick();
    VALUE_IN = 16'd32; VALUE_CHANGE = 1'b1;
    tick();
    checks++; if (READ_EVENT !== 1'b1) begin failures++; $display("FAIL single_ack got=%0b exp=1", READ_EVENT); end
    checks++; if (EVT_VALID !== 1'b1) begin failures++; $display("FAIL single_valid got=%0b exp=1", EVT_VALID); end
    checks++; if (EVT_DATA !== 16'd32) begin failures++; $display("FAIL single_data got=%0d exp=32", EVT_DATA); end
    checks++; if (EVT_TS !== 16'd5) begin failures++; $display("FAIL single_ts got=%0d exp=5", EVT_TS); end
    checks++; if (LEVEL !== 4'd1) begin failures++; $display("FAIL single_level got=%0d exp=1", LEVEL); end
    tick();
    checks++; if (READ_EVENT !== 1'b0) begin failures++; $display("FAIL single_ack_width got=%0b exp=0", READ_EVENT); end
    VALUE_CHANGE = 1'b0; EVT_READY = 1'b1;
    tick();
    checks++; if (LEVEL !== 4'd0) begin failures++; $display("FAIL single_drain got=%0d exp=0", LEVEL); end
    EVT_READY = 1'b0;
    tick(); tick();
  endtask

  task automatic test_two_in_order();
    logic [15:0] t0;
    EVT_READY = 1'b0;
    t0 = m_ts;
    VALUE_IN = 16'd32; VALUE_CHANGE = 1'b1;
    tick(); tick();
    VALUE_CHANGE = 1'b0;
    repeat (8) tick();
    VALUE_IN = 16'd15; VALUE_CHANGE = 1'b1;
    tick(); tick();
    VALUE_CHANGE = 1'b0;
    checks++; if (LEVEL !== 4'd2) begin failures++; $display("FAIL order_level got=%0d exp=2", LEVEL); end
    checks++; if (EVT_DATA !== 16'd32) begin failures++; $display("FAIL order_first got=%0d exp=32", EVT_DATA); end
    checks++; if (EVT_TS !== t0) begin failures++; $display("FAIL order_first_ts got=%0d exp=%0d", EVT_TS, t0); end
    EVT_READY = 1'b1;
    tick();
    checks++; if (EVT_DATA !== 16'd15) begin failures++; $display("FAIL order_second got=%0d exp=15", EVT_DATA); end
    checks++; if (EVT_TS !== 16'(t0 + 16'd10)) begin failures++; $display("FAIL order_ts_delta got=%0d exp=%0d", EVT_TS, 16'(t0 + 16'd10)); end
    tick();
    checks++; if (LEVEL !== 4'd0 || EVT_VALID !== 1'b0) begin failures++; $display("FAIL order_drain got=%0d/%0b exp=0/0", LEVEL, EVT_VALID); end
    EVT_READY = 1'b0;
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    EVT_READY = 1'b1; VALUE_CHANGE = 1'b1;
    for (int i = 0; i < 12; i++) begin
      VALUE_IN = 16'($urandom);
      tick();
      if (READ_EVENT === 1'b1) acks++;
      checks++; if (READ_EVENT !== m_ack) begin failures++; $display("FAIL b2b_ack cycle=%0d got=%0b exp=%0b", i, READ_EVENT, m_ack); end
    end
    checks++; if (acks != 4) begin failures++; $display("FAIL b2b_ack_count got=%0d exp=4", acks); end
    VALUE_CHANGE = 1'b0;
    repeat (3) tick();
    checks++; if (LEVEL !== 4'd0) begin failures++; $display("FAIL b2b_drain got=%0d exp=0", LEVEL); end
    EVT_READY = 1'b0;
  endtask

  task automatic test_full();
    EVT_READY = 1'b0; VALUE_CHANGE = 1'b1;
    for (int i = 0; i < 8; i++) begin
      VALUE_IN = 16'h0100 + 16'(i);
      tick(); tick(); tick();
    end
    VALUE_IN = 16'h0099;
    checks++; if (LEVEL !== 4'd8 || FULL !== 1'b1) begin failures++; $display("FAIL full_level got=%0d/%0b exp=8/1", LEVEL, FULL); end
    checks++; if (EVT_DATA !== 16'h0100) begin failures++; $display("FAIL full_head got=%0h exp=100", EVT_DATA); end
`ifdef DELTA_EVENT_LOGGER_DROP_EN
    checks++; if (STALL !== 1'b0) begin failures++; $display("FAIL drop_stall got=%0b exp=0", STALL); end
    tick();
    checks++; if (READ_EVENT !== 1'b1) begin failures++; $display("FAIL drop_ack got=%0b exp=1", READ_EVENT); end
    checks++; if (DROP_COUNT !== 8'd1) begin failures++; $display("FAIL drop_count got=%0d exp=1", DROP_COUNT); end
    checks++; if (LEVEL !== 4'd8 || EVT_DATA !== 16'h0100) begin failures++; $display("FAIL drop_unchanged got=%0d/%0h exp=8/100", LEVEL, EVT_DATA); end
    tick();
    VALUE_CHANGE = 1'b0;
    tick();
`else
    checks++; if (STALL !== 1'b1) begin failures++; $display("FAIL stall_high got=%0b exp=1", STALL); end
    tick(); tick();
    checks++; if (READ_EVENT !== 1'b0 || STALL !== 1'b1) begin failures++; $display("FAIL stall_no_ack got=%0b/%0b exp=0/1", READ_EVENT, STALL); end
    checks++; if (LEVEL !== 4'd8) begin failures++; $display("FAIL stall_level got=%0d exp=8", LEVEL); end
    EVT_READY = 1'b1;
    tick();
    EVT_READY = 1'b0;
    checks++; if (LEVEL !== 4'd7 || READ_EVENT !== 1'b0) begin failures++; $display("FAIL stall_pop got=%0d/%0b exp=7/0", LEVEL, READ_EVENT); end
    checks++; if (STALL !== 1'b0) begin failures++; $display("FAIL stall_fall got=%0b exp=0", STALL); end
    tick();
    checks++; if (READ_EVENT !== 1'b1 || LEVEL !== 4'd8) begin failures++; $display("FAIL stall_capture got=%0b/%0d exp=1/8", READ_EVENT, LEVEL); end
    tick();
    VALUE_CHANGE = 1'b0;
`endif
    EVT_READY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (EVT_DATA !== q_data[0]) begin failures++; $display("FAIL full_drain_data idx=%0d got=%0h exp=%0h", i, EVT_DATA, q_data[0]); end
      tick();
    end
    checks++; if (LEVEL !== 4'd0) begin failures++; $display("FAIL full_drain_level got=%0d exp=0", LEVEL); end
    EVT_READY = 1'b0;
  endtask

  task automatic test_reset_mid();
    EVT_READY = 1'b0; VALUE_CHANGE = 1'b1;
    for (int i = 0; i < 2; i++) begin
      VALUE_IN = 16'h0200 + 16'(i);
      tick(); tick(); tick();
    end
    VALUE_IN = 16'h0333;
    tick();
    checks++; if (READ_EVENT !== 1'b1 || LEVEL !== 4'd3) begin failures++; $display("FAIL mid_setup got=%0b/%0d exp=1/3", READ_EVENT, LEVEL); end
    RST = 1'b1; VALUE_CHANGE = 1'b0;
    tick();
    checks++; if (READ_EVENT !== 1'b0) begin failures++; $display("FAIL mid_ack_cancel got=%0b exp=0", READ_EVENT); end
    checks++; if (LEVEL !== 4'd0 || EVT_VALID !== 1'b0) begin failures++; $display("FAIL mid_flush got=%0d/%0b exp=0/0", LEVEL, EVT_VALID); end
    RST = 1'b0; VALUE_CHANGE = 1'b1; VALUE_IN = 16'h0444;
    tick();
    checks++; if (EVT_TS !== 16'd0 || EVT_DATA !== 16'h0444) begin failures++; $display("FAIL mid_ts_restart got=%0d/%0h exp=0/444", EVT_TS, EVT_DATA); end
    tick();
    VALUE_CHANGE = 1'b0;
    EVT_READY = 1'b1;
    repeat (3) tick();
    EVT_READY = 1'b0;
  endtask

  task automatic test_random();
    bit exp_stall;
    for (int i = 0; i < 400; i++) begin
      VALUE_CHANGE = 1'($urandom);
      VALUE_IN     = 16'($urandom);
      EVT_READY    = (i < 200) ? ($urandom_range(7) == 0) : ($urandom_range(1) == 0);
      tick();
      exp_stall = !DROP_MODE && (m_cool == 0) && VALUE_CHANGE && (q_data.size() == DEPTH);
      checks++; if (READ_EVENT !== m_ack) begin failures++; $display("FAIL rnd_ack cycle=%0d got=%0b exp=%0b", i, READ_EVENT, m_ack); end
      checks++; if (LEVEL !== 4'(q_data.size())) begin failures++; $display("FAIL rnd_level cycle=%0d got=%0d exp=%0d", i, LEVEL, q_data.size()); end
      checks++; if (EVT_VALID !== (q_data.size() > 0)) begin failures++; $display("FAIL rnd_valid cycle=%0d got=%0b", i, EVT_VALID); end
      checks++; if (FULL !== (q_data.size() == DEPTH)) begin failures++; $display("FAIL rnd_full cycle=%0d got=%0b", i, FULL); end
      checks++; if (STALL !== exp_stall) begin failures++; $display("FAIL rnd_stall cycle=%0d got=%0b exp=%0b", i, STALL, exp_stall); end
      if (q_data.size() > 0) begin
        checks++; if (EVT_DATA !== q_data[0] || EVT_TS !== q_ts[0]) begin failures++; $display("FAIL rnd_head cycle=%0d got=%0h/%0d exp=%0h/%0d", i, EVT_DATA, EVT_TS, q_data[0], q_ts[0]); end
      end
`ifdef DELTA_EVENT_LOGGER_DROP_EN
      checks++; if (DROP_COUNT !== 8'(m_drop)) begin failures++; $display("FAIL rnd_drop cycle=%0d got=%0d exp=%0d", i, DROP_COUNT, m_drop); end
`endif
    end
    VALUE_CHANGE = 1'b0;
    EVT_READY = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_capture();
    test_two_in_order();
    test_back_to_back();
    test_full();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/delta_event_logger.md
Name: delta_event_logger

Overview:
- Sits directly downstream of the delta register. Consumes its VALUE_CHANGE flag and VALUE_OUT word.
- Each change is logged as a timestamped entry in a small FIFO. The block then acknowledges the delta register by pulsing READ_EVENT.
- Entries are drained by a consumer (CSR or trace path) through a valid/ready interface.

Parameters:
- DATA_WIDTH, 16, width of the logged value; matches the delta register's DATA_WIDTH.
- TS_WIDTH, 16, width of the free-running timestamp counter.
- DEPTH, 8, FIFO entries; must be a power of 2, minimum 2.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- VALUE_CHANGE  in  1  change-pending flag from the delta register.
- VALUE_IN  in  DATA_WIDTH  VALUE_OUT of the delta register.
- READ_EVENT  out  1  one-cycle acknowledge to the delta register; clears its flag.
- EVT_VALID  out  1  FIFO head entry is valid.
- EVT_READY  in  1  consumer accepts the head entry.
- EVT_DATA  out  DATA_WIDTH  logged value at the FIFO head.
- EVT_TS  out  TS_WIDTH  timestamp at the FIFO head.
- LEVEL  out  $clog2(DEPTH)+1  current FIFO occupancy.
- FULL  out  1  LEVEL == DEPTH.
- STALL  out  1  change pending but FIFO full (no-drop mode only).

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is synchronous, active-high.
- Reset values: READ_EVENT=0, EVT_VALID=0, LEVEL=0, FULL=0, STALL=0, timestamp=0, FSM=IDLE. EVT_DATA and EVT_TS are don't-care while EVT_VALID=0.
- Timestamp: increments by 1 every cycle out of reset and wraps from 2^TS_WIDTH-1 to 0 silently.
- FSM states: IDLE, ACK, SETTLE.
  - IDLE: if VALUE_CHANGE=1 and FIFO not full, write {VALUE_IN, timestamp of that cycle} and go to ACK.
  - IDLE while full: remain in IDLE with STALL=1. Do not ack; the delta register keeps its newest value pending.
  - ACK: READ_EVENT=1 for exactly this cycle, then go to SETTLE.
  - SETTLE: one cycle, ignore VALUE_CHANGE (the delta register clears its flag on the edge after READ_EVENT), then go to IDLE.
- Capture latency: VALUE_CHANGE sampled at edge N; entry visible on EVT_VALID at N+1; READ_EVENT high during cycle N+1.
- Throughput: at most one capture every 3 cycles.
- Output handshake:
  - Pop occurs when EVT_VALID && EVT_READY at a rising edge.
  - EVT_DATA and EVT_TS stay stable while EVT_VALID=1 && EVT_READY=0.
  - FIFO is first-word-fall-through.
- Simultaneous push and pop:
  - When full: the pop frees a slot, but the capture decision uses pre-edge FULL. The capture occurs on the next IDLE cycle.
  - When not full: LEVEL unchanged.
- Pointers: wrap modulo DEPTH. LEVEL never exceeds DEPTH, never underflows; a pop on empty is ignored.
- RST mid-operation: FIFO is flushed, the FSM aborts to IDLE, and any in-flight READ_EVENT is cancelled on that edge.

Optional Feature:
- Macro: DELTA_EVENT_LOGGER_DROP_EN.
- Defined:
  - When full with VALUE_CHANGE=1, the FSM still goes through ACK/SETTLE. READ_EVENT is pulsed and the value is discarded.
  - Added output DROP_COUNT (8 bits) increments per dropped change and saturates at 255; cleared only by RST.
  - STALL is tied 0.
- Undefined: stall behaviour as above; no DROP_COUNT port.

Decomposition:
- Package delta_event_pkg:
  - typedef struct packed for the entry {data, ts};
  - FSM state enum (IDLE, ACK, SETTLE);
  - constant SETTLE_CYCLES=1.
- Sub-module sync_fifo_fwft: parameterised by entry width and DEPTH; ports push/pop/full/empty/level.
- FSM and timestamp counter stay in the top module.

Test Plan:
- Reset, then VALUE_IN=32 with VALUE_CHANGE raised at cycle 5 -> READ_EVENT pulse 1 cycle later; EVT_DATA=32, EVT_TS=5; LEVEL=1.
- Changes to 32 then 15, 10 cycles apart, with EVT_READY=0 -> two entries in order (32, 15) with TS delta 10; then EVT_READY=1 drains both and LEVEL returns to 0.
- VALUE_CHANGE held high continuously -> one READ_EVENT every 3 cycles; no double capture during SETTLE.
- DEPTH=8 filled, ninth change without DROP_EN -> STALL=1 and no READ_EVENT. One pop -> capture on the next IDLE cycle; STALL falls.
- Same fill with DROP_EN defined -> READ_EVENT pulsed, DROP_COUNT=1, LEVEL stays 8, FIFO contents unchanged.
- RST asserted during the ACK state with LEVEL=3 -> next cycle: READ_EVENT=0, LEVEL=0, EVT_VALID=0, timestamp=0.
